// File: rtl/debug_sequencer.sv
// Debug command sequencer: decodes single-byte UART commands to load instruction
// memory, run or single-step the MIPS pipeline, and report cycle count and halt.
module debug_sequencer #(
  parameter int NB_MEM_WIDTH = 8,
  parameter int NB_ADDR      = 32,
  parameter int IMEM_BYTES   = 256,
  parameter int NB_COUNT     = 32
) (
  input  logic                    i_clock,
  input  logic                    i_reset_n,
  input  logic [NB_MEM_WIDTH-1:0] i_rx_data,
  input  logic                    i_rx_valid,
  input  logic                    i_halt,
  output logic                    o_pc_enable,
  output logic                    o_read_enable,
  output logic                    o_control_unit_enable,
  output logic                    o_pc_reset,
  output logic                    o_ID_stage_reset,
  output logic                    o_write_enable,
  output logic [NB_MEM_WIDTH-1:0] o_write_data,
  output logic [NB_ADDR-1:0]      o_write_addr,
  output logic [NB_COUNT-1:0]     o_cycle_count,
  output logic                    o_done,
  output logic                    o_cmd_error
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_LOAD,
    ST_RUN,
    ST_STEP_WAIT,
    ST_STEP_EXEC,
    ST_DONE
  } state_t;

  localparam logic [NB_MEM_WIDTH-1:0] CMD_LOAD  = NB_MEM_WIDTH'(8'h4C);
  localparam logic [NB_MEM_WIDTH-1:0] CMD_CONT  = NB_MEM_WIDTH'(8'h43);
  localparam logic [NB_MEM_WIDTH-1:0] CMD_STEP  = NB_MEM_WIDTH'(8'h53);
  localparam logic [NB_MEM_WIDTH-1:0] CMD_NEXT  = NB_MEM_WIDTH'(8'h4E);
  localparam logic [NB_MEM_WIDTH-1:0] CMD_RESET = NB_MEM_WIDTH'(8'h52);
  localparam logic [NB_ADDR-1:0]      IMEM_LIMIT = NB_ADDR'(IMEM_BYTES);

  state_t                  state_q, state_d;
  logic [7:0]              len_lo_q, len_lo_d;
  logic [15:0]             remain_q, remain_d;
  logic [NB_ADDR-1:0]      addr_q, addr_d;
  logic                    wr_en_q, wr_en_d;
  logic [NB_MEM_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [NB_ADDR-1:0]      wr_addr_q, wr_addr_d;
  logic [NB_COUNT-1:0]     count_q, count_d;
  logic                    err_q, err_d;
  logic                    en_q, en_d;
  logic                    pipe_rst_q, pipe_rst_d;
  logic                    done_q, done_d;

  always_comb begin
    state_d   = state_q;
    len_lo_d  = len_lo_q;
    remain_d  = remain_q;
    addr_d    = addr_q;
    wr_en_d   = 1'b0;
    wr_data_d = wr_data_q;
    wr_addr_d = wr_addr_q;
    count_d   = count_q;
    err_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_rx_valid) begin
          if (i_rx_data == CMD_LOAD) begin
            state_d = ST_LEN_LO;
          end else if (i_rx_data == CMD_CONT) begin
            state_d = ST_RUN;
            count_d = '0;
          end else if (i_rx_data == CMD_STEP) begin
            state_d = ST_STEP_WAIT;
            count_d = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_LEN_LO: begin
        if (i_rx_valid) begin
          len_lo_d = i_rx_data[7:0];
          state_d  = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        if (i_rx_valid) begin
          if ({i_rx_data[7:0], len_lo_q} == 16'd0) begin
            state_d = ST_IDLE;
          end else begin
            state_d  = ST_LOAD;
            remain_d = {i_rx_data[7:0], len_lo_q};
            addr_d   = '0;
          end
        end
      end
      ST_LOAD: begin
        // Every byte is payload here; bytes past the memory end are dropped and
        // flagged once, when the address first reaches the limit.
        if (i_rx_valid) begin
          if (addr_q < IMEM_LIMIT) begin
            wr_en_d   = 1'b1;
            wr_data_d = i_rx_data;
            wr_addr_d = addr_q;
          end else if (addr_q == IMEM_LIMIT) begin
            err_d = 1'b1;
          end
          addr_d   = addr_q + NB_ADDR'(1);
          remain_d = remain_q - 16'd1;
          if (remain_q == 16'd1) begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_RUN: begin
        count_d = count_q + NB_COUNT'(1);
        if (i_rx_valid && (i_rx_data == CMD_RESET)) begin
          state_d = ST_IDLE;
        end else begin
          err_d = i_rx_valid;
          if (i_halt) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_STEP_WAIT: begin
        if (i_rx_valid) begin
          if (i_rx_data == CMD_NEXT) begin
            state_d = ST_STEP_EXEC;
          end else if (i_rx_data == CMD_RESET) begin
            state_d = ST_IDLE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_STEP_EXEC: begin
        count_d = count_q + NB_COUNT'(1);
        err_d   = i_rx_valid;
        state_d = i_halt ? ST_DONE : ST_STEP_WAIT;
      end
      ST_DONE: begin
        if (i_rx_valid) begin
          if (i_rx_data == CMD_RESET) begin
            state_d = ST_IDLE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Status outputs are decoded from the next state so they line up with it.
    en_d       = (state_d == ST_RUN) || (state_d == ST_STEP_EXEC);
    pipe_rst_d = (state_d == ST_IDLE) || (state_d == ST_LEN_LO) ||
                 (state_d == ST_LEN_HI) || (state_d == ST_LOAD);
    done_d     = (state_d == ST_DONE);
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= ST_IDLE;
      len_lo_q   <= '0;
      remain_q   <= '0;
      addr_q     <= '0;
      wr_en_q    <= 1'b0;
      wr_data_q  <= '0;
      wr_addr_q  <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
      en_q       <= 1'b0;
      pipe_rst_q <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_lo_q   <= len_lo_d;
      remain_q   <= remain_d;
      addr_q     <= addr_d;
      wr_en_q    <= wr_en_d;
      wr_data_q  <= wr_data_d;
      wr_addr_q  <= wr_addr_d;
      count_q    <= count_d;
      err_q      <= err_d;
      en_q       <= en_d;
      pipe_rst_q <= pipe_rst_d;
      done_q     <= done_d;
    end
  end

  assign o_pc_enable           = en_q;
  assign o_read_enable         = en_q;
  assign o_control_unit_enable = en_q;
  assign o_pc_reset            = pipe_rst_q;
  assign o_ID_stage_reset      = pipe_rst_q;
  assign o_write_enable        = wr_en_q;
  assign o_write_data          = wr_data_q;
  assign o_write_addr          = wr_addr_q;
  assign o_cycle_count         = count_q;
  assign o_done                = done_q;
  assign o_cmd_error           = err_q;

endmodule

// File: tb/tb_debug_sequencer.sv
// Bench for debug_sequencer: directed command scenarios plus randomized byte
// traffic, checked every cycle against a command-level behavioural model.
module tb_debug_sequencer;

  localparam int IMEM = 4;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        halt;
  logic        pc_en, rd_en, cu_en, pc_rst, id_rst, we, done, cerr;
  logic [7:0]  wd;
  logic [31:0] wa, cnt;

  debug_sequencer #(
    .NB_MEM_WIDTH(8),
    .NB_ADDR(32),
    .IMEM_BYTES(IMEM),
    .NB_COUNT(32)
  ) dut (
    .i_clock(clk),
    .i_reset_n(rst_n),
    .i_rx_data(rx_data),
    .i_rx_valid(rx_valid),
    .i_halt(halt),
    .o_pc_enable(pc_en),
    .o_read_enable(rd_en),
    .o_control_unit_enable(cu_en),
    .o_pc_reset(pc_rst),
    .o_ID_stage_reset(id_rst),
    .o_write_enable(we),
    .o_write_data(wd),
    .o_write_addr(wa),
    .o_cycle_count(cnt),
    .o_done(done),
    .o_cmd_error(cerr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: operating mode plus load bookkeeping.
  localparam int M_IDLE = 0, M_HDR = 1, M_DATA = 2, M_RUN = 3,
                 M_WAIT = 4, M_EXEC = 5, M_DONE = 6;
  int          m_mode, m_hdr_n, m_len, m_idx;
  bit          m_ovf;
  logic        e_en, e_rst, e_we, e_done, e_err;
  logic [7:0]  e_wd;
  logic [31:0] e_wa, e_cnt;

  task automatic model_reset();
    m_mode = M_IDLE; m_hdr_n = 0; m_len = 0; m_idx = 0; m_ovf = 0;
    e_en = 0; e_rst = 1; e_we = 0; e_done = 0; e_err = 0;
    e_wd = 0; e_wa = 0; e_cnt = 0;
  endtask

  task automatic model_step();
    bit v;
    int b;
    v = rx_valid;
    b = int'(rx_data);
    e_we = 0;
    e_err = 0;
    case (m_mode)
      M_IDLE: if (v) begin
        if (b == 'h4C) begin m_mode = M_HDR; m_hdr_n = 0; m_len = 0; end
        else if (b == 'h43) begin m_mode = M_RUN; e_cnt = 0; end
        else if (b == 'h53) begin m_mode = M_WAIT; e_cnt = 0; end
        else e_err = 1;
      end
      M_HDR: if (v) begin
        m_len = m_len + (b << (8 * m_hdr_n));
        m_hdr_n++;
        if (m_hdr_n == 2) begin
          m_idx = 0; m_ovf = 0;
          m_mode = (m_len == 0) ? M_IDLE : M_DATA;
        end
      end
      M_DATA: if (v) begin
        if (m_idx < IMEM) begin
          e_we = 1; e_wd = b[7:0]; e_wa = m_idx;
        end else if (!m_ovf) begin
          e_err = 1; m_ovf = 1;
        end
        m_idx++;
        if (m_idx == m_len) m_mode = M_IDLE;
      end
      M_RUN: begin
        e_cnt = e_cnt + 1;
        if (v && b == 'h52) m_mode = M_IDLE;
        else begin
          if (v) e_err = 1;
          if (halt) m_mode = M_DONE;
        end
      end
      M_WAIT: if (v) begin
        if (b == 'h4E) m_mode = M_EXEC;
        else if (b == 'h52) m_mode = M_IDLE;
        else e_err = 1;
      end
      M_EXEC: begin
        e_cnt = e_cnt + 1;
        if (v) e_err = 1;
        m_mode = halt ? M_DONE : M_WAIT;
      end
      default: if (v) begin
        if (b == 'h52) m_mode = M_IDLE;
        else e_err = 1;
      end
    endcase
    e_en   = (m_mode == M_RUN) || (m_mode == M_EXEC);
    e_rst  = (m_mode <= M_DATA);
    e_done = (m_mode == M_DONE);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_step();
  end

  // Per-cycle compare plus event logs used by the directed scenarios.
  bit          chk_en = 0;
  logic [31:0] wq_addr[$];
  logic [7:0]  wq_data[$];
  int          err_cnt = 0;
  int          en_cnt = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("pc_enable", {31'd0, pc_en}, {31'd0, e_en});
      chk("read_enable", {31'd0, rd_en}, {31'd0, e_en});
      chk("cu_enable", {31'd0, cu_en}, {31'd0, e_en});
      chk("pc_reset", {31'd0, pc_rst}, {31'd0, e_rst});
      chk("id_reset", {31'd0, id_rst}, {31'd0, e_rst});
      chk("write_enable", {31'd0, we}, {31'd0, e_we});
      if (e_we) begin
        chk("write_data", {24'd0, wd}, {24'd0, e_wd});
        chk("write_addr", wa, e_wa);
      end
      chk("cycle_count", cnt, e_cnt);
      chk("done", {31'd0, done}, {31'd0, e_done});
      chk("cmd_error", {31'd0, cerr}, {31'd0, e_err});
      if (we) begin
        wq_addr.push_back(wa);
        wq_data.push_back(wd);
      end
      if (cerr) err_cnt++;
      if (pc_en) en_cnt++;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_logs();
    wq_addr.delete();
    wq_data.delete();
    err_cnt = 0;
    en_cnt = 0;
  endtask

  logic [7:0] exp_ld [4] = '{8'h11, 8'h4C, 8'h33, 8'h44};

  initial begin
    rst_n = 1'b0;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    halt = 1'b0;
    @(posedge clk);
    chk_en = 1;
    @(negedge clk);
    // Bytes arriving during reset must be ignored.
    for (int i = 0; i < 6; i++) begin
      rx_data = (i % 2 == 0) ? 8'h43 : 8'h4C;
      rx_valid = 1'b1;
      halt = 1'b1;
      @(negedge clk);
      chk("rst_pc_reset", {31'd0, pc_rst}, 32'd1);
      chk("rst_pc_enable", {31'd0, pc_en}, 32'd0);
      chk("rst_write_enable", {31'd0, we}, 32'd0);
    end
    rx_valid = 1'b0;
    halt = 1'b0;
    rst_n = 1'b1;
    idle(2);

    // Load four bytes, one of which equals a command code.
    clear_logs();
    send_byte(8'h4C); send_byte(8'h04); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h4C); send_byte(8'h33); send_byte(8'h44);
    idle(2);
    chk("load_nwrites", wq_addr.size(), 32'd4);
    for (int i = 0; i < 4 && i < wq_addr.size(); i++) begin
      chk("load_addr", wq_addr[i], i);
      chk("load_data", {24'd0, wq_data[i]}, {24'd0, exp_ld[i]});
    end
    send_byte(8'h43);
    idle(2);
    chk("after_load_run", {31'd0, pc_en}, 32'd1);
    send_byte(8'h52);
    idle(2);

    // Overflow: six bytes into a four-byte memory.
    clear_logs();
    send_byte(8'h4C); send_byte(8'h06); send_byte(8'h00);
    for (int i = 0; i < 6; i++) send_byte(8'hA0 + 8'(i));
    idle(2);
    chk("ovf_nwrites", wq_addr.size(), 32'd4);
    chk("ovf_err_pulses", err_cnt, 32'd1);
    chk("ovf_idle_reset", {31'd0, pc_rst}, 32'd1);

    // Continuous run with halt on the tenth executed cycle.
    clear_logs();
    send_byte(8'h43);
    idle(9);
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    idle(2);
    chk("run_en_cycles", en_cnt, 32'd10);
    chk("run_count", cnt, 32'd10);
    chk("run_done", {31'd0, done}, 32'd1);
    send_byte(8'h52);
    idle(1);
    chk("run_r_done", {31'd0, done}, 32'd0);
    chk("run_r_reset", {31'd0, pc_rst}, 32'd1);

    // Single-step three times, halting on the third.
    clear_logs();
    send_byte(8'h53);
    idle(2);
    for (int i = 0; i < 3; i++) begin
      send_byte(8'h4E);
      halt = (i == 2);
      @(negedge clk);
      halt = 1'b0;
      idle(2);
    end
    chk("step_en_cycles", en_cnt, 32'd3);
    chk("step_count", cnt, 32'd3);
    chk("step_done", {31'd0, done}, 32'd1);
    err_cnt = 0;
    send_byte(8'h4E);
    idle(1);
    chk("done_n_err", err_cnt, 32'd1);
    send_byte(8'h52);
    idle(2);

    // Illegal byte in IDLE, then simultaneous abort and halt in RUN.
    err_cnt = 0;
    send_byte(8'h4E);
    idle(1);
    chk("idle_n_err", err_cnt, 32'd1);
    chk("idle_n_count_held", cnt, 32'd3);
    send_byte(8'h43);
    idle(2);
    rx_data = 8'h52;
    rx_valid = 1'b1;
    halt = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    halt = 1'b0;
    idle(1);
    chk("r_beats_halt_done", {31'd0, done}, 32'd0);
    chk("r_beats_halt_reset", {31'd0, pc_rst}, 32'd1);

    // Randomized traffic with occasional asynchronous resets.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 399) == 0) begin
        rx_valid = 1'b0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
      rx_valid = ($urandom_range(0, 99) < 30);
      if (m_mode == M_HDR) begin
        rx_data = (m_hdr_n == 0) ? 8'($urandom_range(0, 9)) : 8'h00;
      end else begin
        case ($urandom_range(0, 6))
          0: rx_data = 8'h4C;
          1: rx_data = 8'h43;
          2: rx_data = 8'h53;
          3: rx_data = 8'h4E;
          4: rx_data = 8'h52;
          default: rx_data = 8'($urandom_range(0, 255));
        endcase
      end
      halt = ($urandom_range(0, 9) == 0);
    end
    rx_valid = 1'b0;
    halt = 1'b0;
    idle(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
